// File: rtl/serial_bit_collector.sv
// Serial-to-word collector: gathers qualified bits MSB-first into WIDTH-bit words and queues them in a 2-entry valid/ready buffer.
// Optional feature macro PARITY_CHECK_EN appends an even-parity bit to every word and adds the parity_err output.
module serial_bit_collector #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      bit_in,
   input  logic                      bit_vld,
   input  logic                      frame_rst,
   output logic [WIDTH-1:0]          out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      overflow,
   input  logic                      ovf_clr,
   output logic [$clog2(WIDTH):0]    bit_cnt
`ifdef PARITY_CHECK_EN
   ,
   output logic                      parity_err
`endif
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam int PW = $clog2(DEPTH);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [0:0] {
      ST_COLLECT = 1'b0,
      ST_PARITY  = 1'b1
   } state_e;

`ifdef PARITY_CHECK_EN
   // Returns 1 when the data word plus its parity bit has an odd number of ones.
   function automatic logic parity_bad(input logic [WIDTH-1:0] word, input logic par);
      return (^word) ^ par;
   endfunction
`endif

   state_e               state_r, state_n;
   logic [WIDTH-1:0]     shreg_r, shreg_n;
   logic [CW-1:0]        cnt_r, cnt_n;
   logic [PW:0]          wr_ptr_r, wr_ptr_n, rd_ptr_r, rd_ptr_n;
   logic [WIDTH-1:0]     mem_r [DEPTH];
   logic [WIDTH-1:0]     mem_n [DEPTH];
   logic [WIDTH-1:0]     out_data_r, out_data_n;
   logic                 out_valid_r, out_valid_n;
   logic                 overflow_r, overflow_n;
   logic                 perr_r, perr_n;
   logic                 push_s, pop_s, full_s, accept_s;
   logic [WIDTH-1:0]     word_s;

   // Word assembly FSM: shift register, bit counter and word-complete strobe.
   always_comb begin
      state_n = state_r;
      shreg_n = shreg_r;
      cnt_n   = cnt_r;
      push_s  = 1'b0;
      word_s  = shreg_r;
      perr_n  = 1'b0;
      if (frame_rst) begin
         state_n = ST_COLLECT;
         shreg_n = '0;
         cnt_n   = '0;
      end else if (bit_vld) begin
         case (state_r)
            ST_COLLECT: begin
               shreg_n = {shreg_r[WIDTH-2:0], bit_in};
               if (cnt_r == CW'(WIDTH - 1)) begin
`ifdef PARITY_CHECK_EN
                  cnt_n   = CW'(WIDTH);
                  state_n = ST_PARITY;
`else
                  cnt_n   = '0;
                  push_s  = 1'b1;
                  word_s  = {shreg_r[WIDTH-2:0], bit_in};
`endif
               end else begin
                  cnt_n = cnt_r + CNT_ONE;
               end
            end
            ST_PARITY: begin
               push_s  = 1'b1;
               word_s  = shreg_r;
`ifdef PARITY_CHECK_EN
               perr_n  = parity_bad(shreg_r, bit_in);
`endif
               shreg_n = '0;
               cnt_n   = '0;
               state_n = ST_COLLECT;
            end
            default: begin
               state_n = ST_COLLECT;
               cnt_n   = '0;
            end
         endcase
      end else begin
         state_n = state_r;
      end
   end

   // Output buffer: pop before push so a full buffer can accept a word on a draining cycle.
   always_comb begin
      pop_s    = out_valid_r & out_ready;
      full_s   = (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]) && (wr_ptr_r[PW] != rd_ptr_r[PW]);
      accept_s = push_s & (~full_s | pop_s);
      rd_ptr_n = rd_ptr_r + {{PW{1'b0}}, pop_s};
      wr_ptr_n = wr_ptr_r + {{PW{1'b0}}, accept_s};
      mem_n    = mem_r;
      if (accept_s) begin
         mem_n[wr_ptr_r[PW-1:0]] = word_s;
      end else begin
         mem_n = mem_r;
      end
      out_data_n  = mem_n[rd_ptr_n[PW-1:0]];
      out_valid_n = (rd_ptr_n != wr_ptr_n);
      if (push_s && !accept_s) begin
         overflow_n = 1'b1;
      end else if (ovf_clr) begin
         overflow_n = 1'b0;
      end else begin
         overflow_n = overflow_r;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_COLLECT;
         shreg_r     <= '0;
         cnt_r       <= '0;
         wr_ptr_r    <= '0;
         rd_ptr_r    <= '0;
         for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
         out_data_r  <= '0;
         out_valid_r <= 1'b0;
         overflow_r  <= 1'b0;
         perr_r      <= 1'b0;
      end else begin
         state_r     <= state_n;
         shreg_r     <= shreg_n;
         cnt_r       <= cnt_n;
         wr_ptr_r    <= wr_ptr_n;
         rd_ptr_r    <= rd_ptr_n;
         for (int i = 0; i < DEPTH; i++) mem_r[i] <= mem_n[i];
         out_data_r  <= out_data_n;
         out_valid_r <= out_valid_n;
         overflow_r  <= overflow_n;
         perr_r      <= perr_n;
      end
   end

   assign out_data  = out_data_r;
   assign out_valid = out_valid_r;
   assign overflow  = overflow_r;
   assign bit_cnt   = cnt_r;
`ifdef PARITY_CHECK_EN
   assign parity_err = perr_r;
`else
   logic unused_perr_s;
   assign unused_perr_s = perr_r;
`endif

endmodule

// File: tb/tb_serial_bit_collector.sv
// Randomized bench for serial_bit_collector against a queue-based model of the bit stream and word buffer.
module tb_serial_bit_collector;

   localparam int WIDTH = 8;
   localparam int CW    = $clog2(WIDTH) + 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             bit_in = 1'b0;
   logic             bit_vld = 1'b0;
   logic             frame_rst = 1'b0;
   logic             out_ready = 1'b0;
   logic             ovf_clr = 1'b0;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             overflow;
   logic [CW-1:0]    bit_cnt;
`ifdef PARITY_CHECK_EN
   logic             parity_err;
`endif

   int checks = 0;
   int failures = 0;

   bit m_bits[$];
   int m_q[$];
   bit m_ovf = 1'b0;
   bit m_perr = 1'b0;

   serial_bit_collector #(.WIDTH(WIDTH), .DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_vld(bit_vld), .frame_rst(frame_rst),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .overflow(overflow), .ovf_clr(ovf_clr), .bit_cnt(bit_cnt)
`ifdef PARITY_CHECK_EN
      , .parity_err(parity_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cmp_model();
      check("valid", 32'(out_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) check("data", 32'(out_data), m_q[0]);
      check("ovf", 32'(overflow), 32'(m_ovf));
      check("cnt", 32'(bit_cnt), m_bits.size());
`ifdef PARITY_CHECK_EN
      check("perr", 32'(parity_err), 32'(m_perr));
`endif
   endtask

   // Model of one clock edge given the inputs currently driven.
   task automatic model_update();
      bit pop;
      bit push;
      bit drop;
      int w;
      pop  = (m_q.size() > 0) && out_ready;
      push = 1'b0;
      w    = 0;
      m_perr = 1'b0;
      if (frame_rst) begin
         m_bits.delete();
      end else if (bit_vld) begin
`ifdef PARITY_CHECK_EN
         if (m_bits.size() == WIDTH) begin
            foreach (m_bits[i]) w = (w << 1) | int'(m_bits[i]);
            m_perr = (^w) ^ bit_in;
            push = 1'b1;
            m_bits.delete();
         end else begin
            m_bits.push_back(bit_in);
         end
`else
         m_bits.push_back(bit_in);
         if (m_bits.size() == WIDTH) begin
            foreach (m_bits[i]) w = (w << 1) | int'(m_bits[i]);
            push = 1'b1;
            m_bits.delete();
         end
`endif
      end
      if (pop) void'(m_q.pop_front());
      drop = push && (m_q.size() >= 2);
      if (push && !drop) m_q.push_back(w);
      if (drop) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
   endtask

   task automatic step();
      cmp_model();
      model_update();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send_bits(input logic [15:0] v, input int n, input bit rdy_last, input bit gaps);
      for (int i = n - 1; i >= 0; i--) begin
         if (gaps && (i % 2 == 1)) begin
            bit_vld = 1'b0; bit_in = 1'($urandom); out_ready = 1'b0;
            step();
         end
         bit_vld = 1'b1; bit_in = v[i];
         out_ready = (i == 0) ? rdy_last : 1'b0;
         step();
      end
      bit_vld = 1'b0; out_ready = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] w, input bit rdy_last, input bit gaps);
`ifdef PARITY_CHECK_EN
      send_bits({7'b0, w, ^w}, 9, rdy_last, gaps);
`else
      send_bits({8'b0, w}, 8, rdy_last, gaps);
`endif
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      check("rst_cnt", 32'(bit_cnt), 32'd0);
      rst_n = 1'b1;
      step();

      // A5 with consumer ready: one-cycle valid
      send_word(8'hA5, 1'b1, 1'b0);
      check("a5_data", 32'(out_data), 32'hA5);
      check("a5_valid", 32'(out_valid), 32'd1);
      check("a5_cnt", 32'(bit_cnt), 32'd0);
      out_ready = 1'b1;
      step();
      check("a5_gone", 32'(out_valid), 32'd0);
      out_ready = 1'b0;

      // Three words with consumer stalled: third dropped
      send_word(8'h11, 1'b0, 1'b0);
      send_word(8'h22, 1'b0, 1'b0);
      send_word(8'h33, 1'b0, 1'b0);
      check("full_head", 32'(out_data), 32'h11);
      check("full_ovf", 32'(overflow), 32'd1);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      check("ovf_clr", 32'(overflow), 32'd0);
      check("held_head", 32'(out_data), 32'h11);

      // Full buffer, completion coincides with a pop
      send_word(8'h44, 1'b1, 1'b0);
      check("swap_head", 32'(out_data), 32'h22);
      check("swap_ovf", 32'(overflow), 32'd0);
      out_ready = 1'b1;
      step();
      check("swap_next", 32'(out_data), 32'h44);
      step();
      check("swap_empty", 32'(out_valid), 32'd0);
      out_ready = 1'b0;

      // Partial word discarded by frame_rst, then a gapped word
      send_bits(16'h000B, 4, 1'b0, 1'b0);
      frame_rst = 1'b1; bit_vld = 1'b1; bit_in = 1'b1;
      step();
      frame_rst = 1'b0; bit_vld = 1'b0;
      check("frst_cnt", 32'(bit_cnt), 32'd0);
      send_word(8'h3C, 1'b0, 1'b1);
      check("frst_data", 32'(out_data), 32'h3C);
      out_ready = 1'b1;
      step();
      check("frst_only", 32'(out_valid), 32'd0);
      out_ready = 1'b0;

`ifdef PARITY_CHECK_EN
      send_bits({7'b0, 8'hA5, 1'b1}, 9, 1'b0, 1'b0);
      check("perr_pulse", 32'(parity_err), 32'd1);
      check("perr_push", 32'(out_data), 32'hA5);
      step();
      check("perr_end", 32'(parity_err), 32'd0);
      send_bits({7'b0, 8'hA5, 1'b0}, 9, 1'b0, 1'b0);
      check("perr_none", 32'(parity_err), 32'd0);
      out_ready = 1'b1;
      repeat (3) step();
      out_ready = 1'b0;
`endif

      // Randomized traffic
      for (int n = 0; n < 1500; n++) begin
         bit_vld   = ($urandom_range(0, 9) < 7);
         bit_in    = 1'($urandom);
         out_ready = 1'($urandom);
         frame_rst = ($urandom_range(0, 99) < 3);
         ovf_clr   = ($urandom_range(0, 99) < 5);
         step();
      end
      bit_vld = 1'b0; frame_rst = 1'b0; ovf_clr = 1'b0;

      // Asynchronous reset mid-word with a full, overflowed buffer
      out_ready = 1'b1;
      repeat (3) step();
      out_ready = 1'b0;
      frame_rst = 1'b1;
      step();
      frame_rst = 1'b0;
      send_word(8'h5A, 1'b0, 1'b0);
      send_word(8'h66, 1'b0, 1'b0);
      send_word(8'h77, 1'b0, 1'b0);
      send_bits(16'h0016, 5, 1'b0, 1'b0);
      check("pre_cnt", 32'(bit_cnt), 32'd5);
      check("pre_ovf", 32'(overflow), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_cnt", 32'(bit_cnt), 32'd0);
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_ovf", 32'(overflow), 32'd0);
      m_bits.delete();
      m_q.delete();
      m_ovf = 1'b0;
      m_perr = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
